// File: rtl/conv_seq_fsm.sv
// rtl/conv_seq_fsm.sv - convolution sequencer: row/column/channel walk with adder-tree result tracking
module conv_seq_fsm #(
    parameter int RAM_SR_DEPTH  = 4,
    parameter int NUM_SR_ROWS   = 4,
    parameter int MA_TREE_DEPTH = 4,
    parameter int NUM_CHANNELS  = 2,
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int COL_W = (RAM_SR_DEPTH > 1) ? $clog2(RAM_SR_DEPTH) : 1,
    localparam int ROW_W = (NUM_SR_ROWS > 1) ? $clog2(NUM_SR_ROWS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            input_start,
    input  logic            row_shift_in_rdy,
    input  logic            abort,
    output logic            sr_enable,
    output logic            shift_row_up,
    output logic            acc_clear,
    output logic [CH_W-1:0] channel_idx,
    output logic            result_valid,
    output logic            conv_done,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_ROW_UP,
        S_NEXT_CH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(RAM_SR_DEPTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_SR_ROWS - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [MA_TREE_DEPTH-1:0] dl_q, dl_d;
    logic [MA_TREE_DEPTH-1:0] dl_head;
    logic                     abort_hit;
    logic                     final_sr;
    logic                     drain_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            dl_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
            dl_q    <= dl_d;
        end
    end

    // Only the final stage may still be set once the last pulse is leaving the line.
    always_comb begin
        dl_head                    = dl_q;
        dl_head[MA_TREE_DEPTH-1]   = 1'b0;
        drain_empty                = (dl_head == '0);
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        ch_d         = ch_q;
        sr_enable    = 1'b0;
        shift_row_up = 1'b0;
        acc_clear    = 1'b0;
        conv_done    = 1'b0;
        final_sr     = 1'b0;
        abort_hit    = abort && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (input_start) begin
                    state_d = S_SHIFT;
                    col_d   = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end
            S_SHIFT: begin
                sr_enable = 1'b1;
                acc_clear = (row_q == '0) && (col_q == '0);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q != LAST_ROW) begin
                        state_d = S_ROW_UP;
                    end else begin
                        final_sr = 1'b1;
                        state_d  = (ch_q != LAST_CH) ? S_NEXT_CH : S_DRAIN;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_ROW_UP: begin
                shift_row_up = row_shift_in_rdy;
                if (row_shift_in_rdy) begin
                    row_d   = row_q + ROW_W'(1);
                    col_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_NEXT_CH: begin
                if (row_shift_in_rdy) begin
                    ch_d    = ch_q + CH_W'(1);
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                conv_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d   = S_IDLE;
            conv_done = 1'b0;
            final_sr  = 1'b0;
        end

        if (state_d == S_IDLE) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
        end
    end

    // Delay line models the adder-tree latency; it runs regardless of FSM state.
    always_comb begin
        dl_d    = '0;
        dl_d[0] = final_sr;
        for (int i = 1; i < MA_TREE_DEPTH; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        if (abort_hit) begin
            dl_d = '0;
        end
    end

    assign result_valid = dl_q[MA_TREE_DEPTH-1] && !abort_hit;
    assign channel_idx  = ch_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_seq_fsm.sv
// tb/tb_conv_seq_fsm.sv - directed self-checking bench for conv_seq_fsm
module tb_conv_seq_fsm;

    logic clock = 1'b0;
    logic reset;
    logic input_start;
    logic start2;
    logic row_shift_in_rdy;
    logic abort;

    logic       sr_enable, shift_row_up, acc_clear, result_valid, conv_done, busy;
    logic [0:0] channel_idx;
    logic       sr2, sru2, acc2, rv2, done2, busy2;
    logic [0:0] ch2;

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] t_sr, t_sru, t_acc, t_rv, t_done, t_busy, t_ch;
    logic [127:0] u_sr, u_sru, u_rv, u_done, u_busy, u_acc;

    conv_seq_fsm dut (
        .clock           (clock),
        .reset           (reset),
        .input_start     (input_start),
        .row_shift_in_rdy(row_shift_in_rdy),
        .abort           (abort),
        .sr_enable       (sr_enable),
        .shift_row_up    (shift_row_up),
        .acc_clear       (acc_clear),
        .channel_idx     (channel_idx),
        .result_valid    (result_valid),
        .conv_done       (conv_done),
        .busy            (busy)
    );

    conv_seq_fsm #(
        .RAM_SR_DEPTH (2),
        .NUM_SR_ROWS  (2),
        .MA_TREE_DEPTH(4),
        .NUM_CHANNELS (1)
    ) dut_small (
        .clock           (clock),
        .reset           (reset),
        .input_start     (start2),
        .row_shift_in_rdy(row_shift_in_rdy),
        .abort           (abort),
        .sr_enable       (sr2),
        .shift_row_up    (sru2),
        .acc_clear       (acc2),
        .channel_idx     (ch2),
        .result_valid    (rv2),
        .conv_done       (done2),
        .busy            (busy2)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] rng(input int a, input int b);
        logic [127:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Cycle c = interval ending at rising edge c; inputs for cycle c are held across edge c.
    task automatic capture(input int which, input int n, input int rlo, input int rhi,
                           input int ab, input int sx, input int rc);
        t_sr = '0; t_sru = '0; t_acc = '0; t_rv = '0; t_done = '0; t_busy = '0; t_ch = '0;
        u_sr = '0; u_sru = '0; u_rv = '0; u_done = '0; u_busy = '0; u_acc = '0;
        @(negedge clock);
        for (int c = 0; c <= n; c++) begin
            if (c > 0) @(negedge clock);
            input_start      = (which == 0) && ((c == 0) || (c == sx));
            start2           = (which == 1) && (c == 0);
            row_shift_in_rdy = !((c >= rlo) && (c <= rhi));
            abort            = (c == ab);
            reset            = !(c == rc);
            #1;
            t_sr[c] = sr_enable;  t_sru[c] = shift_row_up; t_acc[c] = acc_clear;
            t_rv[c] = result_valid; t_done[c] = conv_done; t_busy[c] = busy;
            t_ch[c] = (channel_idx != 1'b0);
            u_sr[c] = sr2; u_sru[c] = sru2; u_rv[c] = rv2; u_done[c] = done2;
            u_busy[c] = busy2; u_acc[c] = acc2;
        end
        input_start = 1'b0; start2 = 1'b0; abort = 1'b0; row_shift_in_rdy = 1'b1; reset = 1'b1;
    endtask

    logic [127:0] b_sr, b_sru, b_acc, b_rv, b_done, b_busy, b_ch;

    task automatic build_baseline();
        b_sr   = rng(1,4) | rng(6,9) | rng(11,14) | rng(16,19)
               | rng(21,24) | rng(26,29) | rng(31,34) | rng(36,39);
        b_sru  = rng(5,5) | rng(10,10) | rng(15,15) | rng(25,25) | rng(30,30) | rng(35,35);
        b_acc  = rng(1,1) | rng(21,21);
        b_rv   = rng(23,23) | rng(43,43);
        b_done = rng(44,44);
        b_busy = rng(1,44);
        b_ch   = rng(21,44);
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({sr_enable, shift_row_up, acc_clear, result_valid, conv_done, busy, channel_idx} !== 7'b0)
            $display("FAIL reset_outputs: got %b expected 0",
                     {sr_enable, shift_row_up, acc_clear, result_valid, conv_done, busy, channel_idx});
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        capture(2, 10, -1, -1, -1, -1, -1);
        n_total++;
        if ((t_busy | t_sr | t_sru | t_rv | t_done | t_acc) !== '0)
            $display("FAIL idle_no_activity: got %h expected 0", t_busy | t_sr | t_sru | t_rv | t_done | t_acc);
        else n_pass++;
    endtask

    task automatic test_baseline();
        capture(0, 50, -1, -1, -1, -1, -1);
        n_total++; if (t_sr !== b_sr)     $display("FAIL base_sr: got %h expected %h", t_sr, b_sr);         else n_pass++;
        n_total++; if (t_sru !== b_sru)   $display("FAIL base_sru: got %h expected %h", t_sru, b_sru);      else n_pass++;
        n_total++; if (t_acc !== b_acc)   $display("FAIL base_acc: got %h expected %h", t_acc, b_acc);      else n_pass++;
        n_total++; if (t_rv !== b_rv)     $display("FAIL base_rv: got %h expected %h", t_rv, b_rv);         else n_pass++;
        n_total++; if (t_done !== b_done) $display("FAIL base_done: got %h expected %h", t_done, b_done);   else n_pass++;
        n_total++; if (t_busy !== b_busy) $display("FAIL base_busy: got %h expected %h", t_busy, b_busy);   else n_pass++;
        n_total++; if (t_ch !== b_ch)     $display("FAIL base_ch: got %h expected %h", t_ch, b_ch);         else n_pass++;
    endtask

    task automatic test_stall();
        logic [127:0] e_sr, e_sru;
        capture(0, 52, 5, 7, -1, -1, -1);
        e_sr  = rng(1,4) | rng(9,12) | rng(14,17) | rng(19,22)
              | rng(24,27) | rng(29,32) | rng(34,37) | rng(39,42);
        e_sru = rng(8,8) | rng(13,13) | rng(18,18) | rng(28,28) | rng(33,33) | rng(38,38);
        n_total++; if (t_sr !== e_sr)   $display("FAIL stall_sr: got %h expected %h", t_sr, e_sr);     else n_pass++;
        n_total++; if (t_sru !== e_sru) $display("FAIL stall_sru: got %h expected %h", t_sru, e_sru);  else n_pass++;
        n_total++; if (t_rv !== (rng(26,26) | rng(46,46)))
            $display("FAIL stall_rv: got %h expected %h", t_rv, rng(26,26) | rng(46,46)); else n_pass++;
        n_total++; if (t_done !== rng(47,47)) $display("FAIL stall_done: got %h expected %h", t_done, rng(47,47)); else n_pass++;
        n_total++; if (t_acc !== (rng(1,1) | rng(24,24)))
            $display("FAIL stall_acc: got %h expected %h", t_acc, rng(1,1) | rng(24,24)); else n_pass++;
    endtask

    task automatic test_small_config();
        capture(1, 14, -1, -1, -1, -1, -1);
        n_total++; if (u_sr !== (rng(1,2) | rng(4,5)))
            $display("FAIL small_sr: got %h expected %h", u_sr, rng(1,2) | rng(4,5)); else n_pass++;
        n_total++; if (u_sru !== rng(3,3))   $display("FAIL small_sru: got %h expected %h", u_sru, rng(3,3));     else n_pass++;
        n_total++; if (u_rv !== rng(9,9))    $display("FAIL small_rv: got %h expected %h", u_rv, rng(9,9));       else n_pass++;
        n_total++; if (u_done !== rng(10,10)) $display("FAIL small_done: got %h expected %h", u_done, rng(10,10)); else n_pass++;
        n_total++; if (u_busy !== rng(1,10)) $display("FAIL small_busy: got %h expected %h", u_busy, rng(1,10));  else n_pass++;
        n_total++; if (u_acc !== rng(1,1))   $display("FAIL small_acc: got %h expected %h", u_acc, rng(1,1));     else n_pass++;
    endtask

    task automatic test_abort();
        logic [127:0] m12;
        m12 = rng(12,12);
        capture(0, 64, -1, -1, 12, 15, -1);
        n_total++; if ((t_sr & ~m12) !== (rng(1,4) | rng(6,9) | rng(11,11) | (b_sr << 15)))
            $display("FAIL abort_sr: got %h expected %h", t_sr & ~m12, rng(1,4) | rng(6,9) | rng(11,11) | (b_sr << 15));
        else n_pass++;
        n_total++; if (t_busy !== (rng(1,12) | rng(16,59)))
            $display("FAIL abort_busy: got %h expected %h", t_busy, rng(1,12) | rng(16,59)); else n_pass++;
        n_total++; if (t_rv !== (b_rv << 15))   $display("FAIL abort_rv: got %h expected %h", t_rv, b_rv << 15);       else n_pass++;
        n_total++; if (t_done !== (b_done << 15)) $display("FAIL abort_done: got %h expected %h", t_done, b_done << 15); else n_pass++;
        n_total++; if (t_acc !== (rng(1,1) | (b_acc << 15)))
            $display("FAIL abort_acc: got %h expected %h", t_acc, rng(1,1) | (b_acc << 15)); else n_pass++;
        n_total++; if (t_ch !== (b_ch << 15))   $display("FAIL abort_ch: got %h expected %h", t_ch, b_ch << 15);       else n_pass++;
    endtask

    task automatic test_async_reset();
        capture(0, 30, -1, -1, -1, -1, 22);
        n_total++; if (t_sr !== (rng(1,4) | rng(6,9) | rng(11,14) | rng(16,19) | rng(21,21)))
            $display("FAIL rst_sr: got %h expected %h", t_sr, rng(1,4) | rng(6,9) | rng(11,14) | rng(16,19) | rng(21,21));
        else n_pass++;
        n_total++; if (t_busy !== rng(1,21)) $display("FAIL rst_busy: got %h expected %h", t_busy, rng(1,21)); else n_pass++;
        n_total++; if (t_rv !== '0)          $display("FAIL rst_rv: got %h expected 0", t_rv);                else n_pass++;
        n_total++; if (t_done !== '0)        $display("FAIL rst_done: got %h expected 0", t_done);            else n_pass++;
        n_total++; if (t_ch !== rng(21,21))  $display("FAIL rst_ch: got %h expected %h", t_ch, rng(21,21));   else n_pass++;
    endtask

    task automatic test_start_during_shift();
        capture(0, 50, -1, -1, -1, 3, -1);
        n_total++; if (t_sr !== b_sr)     $display("FAIL ign_start_sr: got %h expected %h", t_sr, b_sr);       else n_pass++;
        n_total++; if (t_rv !== b_rv)     $display("FAIL ign_start_rv: got %h expected %h", t_rv, b_rv);       else n_pass++;
        n_total++; if (t_done !== b_done) $display("FAIL ign_start_done: got %h expected %h", t_done, b_done); else n_pass++;
        n_total++; if (t_acc !== b_acc)   $display("FAIL ign_start_acc: got %h expected %h", t_acc, b_acc);    else n_pass++;
    endtask

    task automatic test_abort_with_start_in_idle();
        capture(0, 50, -1, -1, 0, -1, -1);
        n_total++; if (t_sr !== b_sr)     $display("FAIL idle_abort_sr: got %h expected %h", t_sr, b_sr);       else n_pass++;
        n_total++; if (t_done !== b_done) $display("FAIL idle_abort_done: got %h expected %h", t_done, b_done); else n_pass++;
        n_total++; if (t_busy !== b_busy) $display("FAIL idle_abort_busy: got %h expected %h", t_busy, b_busy); else n_pass++;
    endtask

    initial begin
        reset            = 1'b0;
        input_start      = 1'b0;
        start2           = 1'b0;
        row_shift_in_rdy = 1'b1;
        abort            = 1'b0;
        build_baseline();
        test_reset();
        test_baseline();
        test_stall();
        test_small_config();
        test_abort();
        test_async_reset();
        test_start_during_shift();
        test_abort_with_start_in_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_seq_fsm.md
CONV_SEQ_FSM -- requirements
Module: conv_seq_fsm

Interface
REQ-001 SHALL have parameter RAM_SR_DEPTH, default 4: sr_enable cycles per row (>=1).
REQ-002 SHALL have parameter NUM_SR_ROWS, default 4: rows per channel pass (>=2).
REQ-003 SHALL have parameter MA_TREE_DEPTH, default 4: adder-tree pipeline latency in cycles (>=1).
REQ-004 SHALL have parameter NUM_CHANNELS, default 2: channel passes per start (>=1); CH_W = max(1, clog2(NUM_CHANNELS)).
REQ-005 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port input_start  in  1  start request, sampled in IDLE only.
REQ-008 SHALL have port row_shift_in_rdy  in  1  row buffer has next row available.
REQ-009 SHALL have port abort  in  1  synchronous cancel.
REQ-010 SHALL have port sr_enable  out  1  shift-register advance.
REQ-011 SHALL have port shift_row_up  out  1  one-cycle row-advance strobe.
REQ-012 SHALL have port acc_clear  out  1  first sr_enable cycle of each channel.
REQ-013 SHALL have port channel_idx  out  CH_W  channel currently being processed.
REQ-014 SHALL have port result_valid  out  1  adder-tree output valid.
REQ-015 SHALL have port conv_done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port busy  out  1  high in every non-IDLE state.

Function
REQ-017 SHALL implement states IDLE, SHIFT, ROW_UP, NEXT_CH, DRAIN, DONE.
REQ-018 IDLE: input_start high -> SHIFT next cycle; col, row, channel counters cleared; input_start ignored outside IDLE.
REQ-019 SHIFT: sr_enable=1 every cycle; col counts 0..RAM_SR_DEPTH-1; at last col: row<NUM_SR_ROWS-1 -> ROW_UP; last row and channel<NUM_CHANNELS-1 -> NEXT_CH; last row, last channel -> DRAIN.
REQ-020 ROW_UP: sr_enable=0; shift_row_up = row_shift_in_rdy; stays while rdy low; rdy high -> row++, col=0, SHIFT next cycle.
REQ-021 NEXT_CH: sr_enable=0, no shift_row_up; stays while rdy low; rdy high -> channel_idx++, row=0, col=0, SHIFT next cycle.
REQ-022 acc_clear SHALL be high exactly on the first SHIFT cycle of each channel (row 0, col 0).
REQ-023 Unstalled channel pass SHALL take NUM_SR_ROWS*RAM_SR_DEPTH + NUM_SR_ROWS-1 cycles (19 at defaults).
REQ-024 result_valid SHALL pulse one cycle exactly MA_TREE_DEPTH cycles after the final sr_enable cycle of each channel, via a MA_TREE_DEPTH-deep delay line, independent of state.
REQ-025 DRAIN: wait until the delay line is empty (last result_valid emitted), then DONE next cycle.
REQ-026 DONE: conv_done=1 for one cycle, busy=1, -> IDLE; conv_done cycle = last result_valid cycle + 1.
REQ-027 abort high in any non-IDLE state SHALL force IDLE next cycle, clear counters and delay line, suppress result_valid and conv_done; abort in IDLE has no effect.
REQ-028 abort and input_start both high in IDLE: start SHALL proceed (abort ignored in IDLE).
REQ-029 channel_idx SHALL hold its value through DRAIN/DONE and clear on entry to IDLE.

Reset
REQ-030 reset low SHALL immediately force IDLE, all counters and delay line to 0, all outputs 0, regardless of clock.
REQ-031 After reset release the block SHALL wait in IDLE for input_start; no output activity before it.

Verification
REQ-032 Defaults, rdy=1, input_start sampled at edge 0 -> sr_enable cycles 1-4,6-9,11-14,16-19; shift_row_up 5,10,15; result_valid 23; acc_clear 1 and 21; channel_idx=1 from 21; result_valid 43; conv_done 44; busy 1-44.
REQ-033 Defaults, rdy low cycles 5-7 -> shift_row_up at 8, all later events shifted +3, conv_done 47.
REQ-034 NUM_CHANNELS=1, RAM_SR_DEPTH=2, NUM_SR_ROWS=2 -> sr_enable 1-2,4-5; shift_row_up 3; result_valid 9; conv_done 10.
REQ-035 Defaults, abort at cycle 12 -> IDLE at 13, no result_valid, no conv_done; new start at 15 restarts from channel 0 with acc_clear at 16.
REQ-036 Defaults, reset low at cycle 22 (one cycle before first result_valid) -> all outputs 0 immediately, result_valid never asserts, block idle until next input_start.
REQ-037 input_start pulsed during SHIFT (cycle 3) -> ignored, timing identical to REQ-032.
